// File: rtl/nv_nvdla_done_intr_gen_if.sv
// Engine-side bundle for the layer-done interrupt generator.
// The master drives the engine/DMA handshakes; the slave returns done pulses and status.
interface nv_nvdla_done_intr_gen_if #(
  parameter int CNT_W = 10
);
  logic [1:0]       op_en;
  logic             layer_end_vld;
  logic             layer_end_group;
  logic             dma_wr_req_vld;
  logic             dma_wr_req_rdy;
  logic             dma_wr_rsp_vld;
  logic [1:0]       done_intr_pd;
  logic [1:0]       op_done;
  logic [CNT_W-1:0] outstanding_cnt;
  logic [1:0]       pend_cnt;
  logic [2:0]       err_sticky;

  modport master (
    output op_en, layer_end_vld, layer_end_group,
           dma_wr_req_vld, dma_wr_req_rdy, dma_wr_rsp_vld,
    input  done_intr_pd, op_done, outstanding_cnt, pend_cnt, err_sticky
  );

  modport slave (
    input  op_en, layer_end_vld, layer_end_group,
           dma_wr_req_vld, dma_wr_req_rdy, dma_wr_rsp_vld,
    output done_intr_pd, op_done, outstanding_cnt, pend_cnt, err_sticky
  );
endinterface

// File: rtl/nv_nvdla_done_intr_gen.sv
// Layer-done interrupt generator: counts outstanding DMA writes and releases a
// per-group done pulse once every write issued for that layer has been acknowledged.
module nv_nvdla_done_intr_gen #(
  parameter int CNT_W = 10
) (
  input logic                     nvdla_core_clk,
  input logic                     nvdla_core_rst,
  nv_nvdla_done_intr_gen_if.slave intf
);

  typedef struct packed {
    logic             vld;
    logic             grp;
    logic [CNT_W-1:0] rem;
  } entry_t;

  entry_t           q0_q, q0_d, q1_q, q1_d;
  entry_t           dec0, dec1, new_e;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       done_q, done_d;
  logic [2:0]       err_q, err_d;
  logic             acc, rsp, ovf, udf, pop, full, illegal, push;

  always_comb begin
    acc   = intf.dma_wr_req_vld & intf.dma_wr_req_rdy;
    rsp   = intf.dma_wr_rsp_vld;
    cnt_d = cnt_q;
    ovf   = 1'b0;
    udf   = 1'b0;
    if (acc && !rsp) begin
      if (&cnt_q) ovf = 1'b1;
      else        cnt_d = cnt_q + CNT_W'(1);
    end else if (rsp && !acc) begin
      if (cnt_q == '0) udf = 1'b1;
      else             cnt_d = cnt_q - CNT_W'(1);
    end

    pop     = q0_q.vld && (q0_q.rem == '0);
    full    = q0_q.vld && q1_q.vld;
    illegal = intf.layer_end_vld &&
              (!intf.op_en[intf.layer_end_group] || (full && !pop));
    push    = intf.layer_end_vld && !illegal;

    // Only entries already resident see this cycle's response; a new entry
    // takes cnt_d, which has the response deducted already.
    dec0 = q0_q;
    dec1 = q1_q;
    if (rsp && dec0.rem != '0) dec0.rem = dec0.rem - CNT_W'(1);
    if (rsp && dec1.rem != '0) dec1.rem = dec1.rem - CNT_W'(1);

    new_e = '{vld: 1'b1, grp: intf.layer_end_group, rem: cnt_d};

    if (pop) begin
      q0_d = dec1;
      q1_d = '0;
    end else begin
      q0_d = dec0;
      q1_d = dec1;
    end
    if (push) begin
      if (!q0_d.vld) q0_d = new_e;
      else           q1_d = new_e;
    end

    done_d = pop ? (q0_q.grp ? 2'b10 : 2'b01) : 2'b00;
    err_d  = err_q | {illegal, udf, ovf};
  end

  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      q0_q   <= '0;
      q1_q   <= '0;
      cnt_q  <= '0;
      done_q <= 2'b00;
      err_q  <= 3'b000;
    end else begin
      q0_q   <= q0_d;
      q1_q   <= q1_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
      err_q  <= err_d;
    end
  end

  assign intf.done_intr_pd    = done_q;
  assign intf.op_done         = done_q;
  assign intf.outstanding_cnt = cnt_q;
  assign intf.pend_cnt        = {1'b0, q0_q.vld} + {1'b0, q1_q.vld};
  assign intf.err_sticky      = err_q;

endmodule
